// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sound_pkg
// Description : Shared definitions for the sound blocks: counter width,
//               system clock rate and the tone_meter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sound_pkg;

  // Width of all period counters; matches the sound block's max_count.
  localparam int unsigned COUNT_W = 26;

  // System clock frequency in Hz.
  localparam int unsigned CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } tone_meter_state_t;

endpackage
`default_nettype wire

// File: rtl/tone_meter_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchronizer followed by a one-flop edge detector.
//               Either polarity of synchronized transition produces a
//               single-cycle, registered pulse on edge_pulse.
// Ports       : clk        - system clock
//               rst_async  - asynchronous active-high reset
//               din        - asynchronous input
//               edge_pulse - one-cycle pulse per synchronized transition
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge (
  input  logic clk,
  input  logic rst_async,
  input  logic din,
  output logic edge_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic edge_q,  edge_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    // Any difference between consecutive synchronized samples is an edge.
    edge_d  = sync2_q ^ prev_q;
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
    end
  end

  assign edge_pulse = edge_q;

endmodule
`default_nettype wire

// File: rtl/tone_meter.sv
`default_nettype none
// ============================================================================
// Module      : tone_meter
// Description : Measures the half-period of an external square wave in clk
//               cycles and hands the result to the CPU through a
//               valid/ack register with a sticky overrun flag. A silent
//               input is reported once as a result of 0.
// Ports       : clk, rst_async        - clock, async active-high reset
//               tone_in               - asynchronous square wave
//               enable                - measurement enable
//               result_count          - last published half-period (0 = none)
//               result_valid          - result_count holds an unread value
//               result_ack            - CPU read strobe
//               overrun               - an unread result was overwritten
// Revision    : 1.0 - initial release
// ============================================================================
module tone_meter
  import sound_pkg::*;
#(
  parameter logic [COUNT_W-1:0] TIMEOUT_CYCLES  = COUNT_W'(CLK_HZ),
  parameter logic [COUNT_W-1:0] MIN_HALF_PERIOD = COUNT_W'(4)
) (
  input  logic               clk,
  input  logic               rst_async,
  input  logic               tone_in,
  input  logic               enable,
  output logic [COUNT_W-1:0] result_count,
  output logic               result_valid,
  input  logic               result_ack,
  output logic               overrun
);

  logic edge_pulse;

  sync_edge u_sync_edge (
    .clk        (clk),
    .rst_async  (rst_async),
    .din        (tone_in),
    .edge_pulse (edge_pulse)
  );

  tone_meter_state_t  state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] result_count_q, result_count_d;
  logic               result_valid_q, result_valid_d;
  logic               overrun_q, overrun_d;

  logic               publish;
  logic [COUNT_W-1:0] publish_val;
  logic [COUNT_W-1:0] measured;
  logic               ack_accepted;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    publish     = 1'b0;
    publish_val = '0;
    // The counter is cleared on the cycle of the accepted edge, so the
    // elapsed edge-to-edge distance is one more than its current value.
    measured    = count_q + COUNT_W'(1);

    if (!enable) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          count_d = '0;
        end
        ST_ARM: begin
          count_d = '0;
          if (edge_pulse) begin
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (edge_pulse && (measured >= MIN_HALF_PERIOD)) begin
            publish     = 1'b1;
            publish_val = measured;
            count_d     = '0;
          end else if (measured >= TIMEOUT_CYCLES) begin
            // Silence: report 0 once, then wait for a fresh first edge.
            publish     = 1'b1;
            publish_val = '0;
            state_d     = ST_ARM;
            count_d     = '0;
          end else if (count_q >= TIMEOUT_CYCLES) begin
            count_d = TIMEOUT_CYCLES;
          end else begin
            // Glitch edges land here too: they are ignored and counting goes on.
            count_d = measured;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    ack_accepted   = result_ack & result_valid_q;
    result_count_d = publish ? publish_val : result_count_q;
    result_valid_d = publish | (result_valid_q & ~result_ack);
    overrun_d      = overrun_q;
    if (publish && result_valid_q && !result_ack) begin
      overrun_d = 1'b1;
    end else if (ack_accepted && !publish) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      result_count_q <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      result_count_q <= result_count_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign result_count = result_count_q;
  assign result_valid = result_valid_q;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_meter
// Description : Directed self-checking bench for tone_meter. Tone periods are
//               scaled down so that a 1000-cycle timeout can be exercised in
//               the same run as the period measurements.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_meter;
  import sound_pkg::*;

  localparam logic [COUNT_W-1:0] TB_TIMEOUT = 26'd1000;
  localparam logic [COUNT_W-1:0] TB_MIN     = 26'd4;

  logic               clk = 1'b0;
  logic               rst_async;
  logic               tone_in;
  logic               enable;
  logic [COUNT_W-1:0] result_count;
  logic               result_valid;
  logic               result_ack;
  logic               overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_edge = 0;
  int pub_cyc  = 0;
  int t_ref    = 0;
  logic [COUNT_W-1:0] exp_q[$];

  tone_meter #(
    .TIMEOUT_CYCLES  (TB_TIMEOUT),
    .MIN_HALF_PERIOD (TB_MIN)
  ) dut (
    .clk          (clk),
    .rst_async    (rst_async),
    .tone_in      (tone_in),
    .enable       (enable),
    .result_count (result_count),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Toggle tone_in n clock edges after the previous toggle.
  task automatic toggle_at(input int n);
    while (cyc < last_edge + n) tick(1);
    tone_in   = ~tone_in;
    last_edge = cyc;
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0d expected=<scoreboard empty>", tag, result_count);
    end else begin
      chk(tag, 32'(result_count), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n = 0;
    while (result_valid !== 1'b1 && n < bound) begin
      tick(1);
      n++;
    end
    pub_cyc = cyc;
    chk({tag, "_valid"}, 32'(result_valid), 32'd1);
    pop_check(tag);
  endtask

  task automatic do_ack(input string tag);
    result_ack = 1'b1;
    tick(1);
    result_ack = 1'b0;
    chk({tag, "_ack_clears_valid"}, 32'(result_valid), 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (result_valid === 1'b1) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_async  = 1'b1;
    tone_in    = 1'b0;
    enable     = 1'b0;
    result_ack = 1'b0;
    #1;
    chk("reset_count",   32'(result_count), 32'd0);
    chk("reset_valid",   32'(result_valid), 32'd0);
    chk("reset_overrun", 32'(overrun),      32'd0);
    tick(3);
    rst_async = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(2);
    chk("state_arm_after_enable", 32'(dut.state_q), 32'(ST_ARM));

    // Basic measurement with latency check: valid appears 4 edges after a toggle.
    toggle_at(0);
    exp_q.push_back(26'd250);
    toggle_at(250);
    tick(3);
    chk("latency_not_yet", 32'(result_valid), 32'd0);
    tick(1);
    chk("latency_valid", 32'(result_valid), 32'd1);
    pop_check("basic_250");
    do_ack("basic");
    chk("ack_retains_count", 32'(result_count), 32'd250);

    // Scaled 440 Hz style half-periods.
    exp_q.push_back(26'd568);
    toggle_at(568);
    wait_valid("tone_568", 20);
    do_ack("tone_568");
    exp_q.push_back(26'd567);
    toggle_at(567);
    wait_valid("tone_567", 20);
    do_ack("tone_567");

    // Glitch of 2 cycles shortly after an accepted edge.
    exp_q.push_back(26'd250);
    toggle_at(250);
    toggle_at(1);
    toggle_at(2);
    wait_valid("pre_glitch_250", 20);
    do_ack("pre_glitch");
    expect_quiet("glitch_no_publish", 200);
    exp_q.push_back(26'd250);
    toggle_at(247);
    wait_valid("post_glitch_250", 20);
    t_ref = pub_cyc;
    do_ack("post_glitch");

    // Silence: exactly one 0 result TIMEOUT cycles later, then ARM.
    exp_q.push_back(26'd0);
    wait_valid("timeout_zero", 1100);
    chk("timeout_delay", 32'(pub_cyc - t_ref), 32'd1000);
    chk("timeout_state_arm", 32'(dut.state_q), 32'(ST_ARM));
    do_ack("timeout");
    expect_quiet("timeout_once", 1500);

    // Overrun: two results without ack.
    toggle_at(0);
    exp_q.push_back(26'd300);
    toggle_at(300);
    wait_valid("ovr_first_300", 20);
    exp_q.push_back(26'd200);
    toggle_at(200);
    begin
      int n = 0;
      while (overrun !== 1'b1 && n < 20) begin
        tick(1);
        n++;
      end
    end
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_valid_kept", 32'(result_valid), 32'd1);
    pop_check("overrun_second_200");
    do_ack("overrun");
    chk("overrun_cleared_by_ack", 32'(overrun), 32'd0);

    // Publish coincident with ack: valid stays, overrun stays 0.
    exp_q.push_back(26'd150);
    toggle_at(150);
    wait_valid("coinc_first_150", 20);
    exp_q.push_back(26'd160);
    toggle_at(160);
    tick(3);
    result_ack = 1'b1;
    tick(1);
    result_ack = 1'b0;
    chk("coinc_valid_kept", 32'(result_valid), 32'd1);
    chk("coinc_overrun_zero", 32'(overrun), 32'd0);
    pop_check("coinc_second_160");
    do_ack("coinc");

    // Ack with nothing pending is ignored.
    result_ack = 1'b1;
    tick(1);
    result_ack = 1'b0;
    chk("idle_ack_valid", 32'(result_valid), 32'd0);
    chk("idle_ack_count", 32'(result_count), 32'd160);

    // Enable drop forces IDLE and keeps the published result.
    tick(20);
    enable = 1'b0;
    tick(1);
    chk("disable_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("disable_count_kept", 32'(result_count), 32'd160);
    tone_in = 1'b0;
    tick(10);
    enable = 1'b1;
    tick(2);
    toggle_at(0);
    exp_q.push_back(26'd100);
    toggle_at(100);
    wait_valid("pre_reset_100", 20);
    do_ack("pre_reset");

    // Reset in mid half-period: outputs clear immediately, then two edges needed.
    tick(50);
    rst_async = 1'b1;
    #1;
    chk("midrst_count",   32'(result_count), 32'd0);
    chk("midrst_valid",   32'(result_valid), 32'd0);
    chk("midrst_overrun", 32'(overrun),      32'd0);
    tick(2);
    rst_async = 1'b0;
    tick(5);
    toggle_at(0);
    expect_quiet("post_reset_one_edge_quiet", 100);
    exp_q.push_back(26'd120);
    toggle_at(120);
    wait_valid("post_reset_120", 20);
    do_ack("post_reset");

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
